// File: rtl/reg_wb_queue_pkg.sv
// Shared register-file constants for the writeback queue: bus widths, zero word, enable and reset levels.
package reg_wb_queue_pkg;

    localparam int          RegNumLog2  = 5;
    localparam int          RegAddrBusW = RegNumLog2;
    localparam int          RegBusW     = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic        RstEnable    = 1'b0;

endpackage : reg_wb_queue_pkg

// File: rtl/reg_wb_queue_wb_fifo.sv
// In-order writeback storage: two ordered pushes and one pop per cycle.
// The full contents are exposed so the top level can run hazard compares.
module wb_fifo
    import reg_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = RegAddrBusW,
    parameter int DW    = RegBusW,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_a_i,
    input  logic [AW-1:0] push_a_addr_i,
    input  logic [DW-1:0] push_a_data_i,
    input  logic          push_b_i,
    input  logic [AW-1:0] push_b_addr_i,
    input  logic [DW-1:0] push_b_data_i,
    input  logic          pop_i,
    output logic [PW-1:0] rd_ptr_o,
    output logic [CW-1:0] count_o,
    output logic [AW-1:0] addr_o [DEPTH],
    output logic [DW-1:0] data_o [DEPTH]
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] slot_b;
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    // The younger push lands right behind the older one, or at the tail if the older one is absent.
    assign slot_b = wr_ptr_q + PW'(push_a_i);

    // NOTE: every variable written in always_comb gets a value first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_a_i) + PW'(push_b_i);
        rd_ptr_d = rd_ptr_q + PW'(pop_i);
        count_d  = count_q + CW'(push_a_i) + CW'(push_b_i) - CW'(pop_i);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count alone decides which entries are valid, so stale data is never seen.
    always_ff @(posedge clk) begin
        if (push_a_i) begin
            addr_q[wr_ptr_q] <= push_a_addr_i;
            data_q[wr_ptr_q] <= push_a_data_i;
        end
        if (push_b_i) begin
            addr_q[slot_b] <= push_b_addr_i;
            data_q[slot_b] <= push_b_data_i;
        end
    end

    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;
    assign addr_o   = addr_q;
    assign data_o   = data_q;

endmodule : wb_fifo

// File: rtl/reg_wb_queue.sv
// GPR write-port driver: arbitrates load/ALU writebacks into a FIFO and drains one write per cycle.
// Optional macro WB_FWD_EN adds chk_fwd_valid/chk_fwd_data for youngest-match bypass.
module reg_wb_queue
    import reg_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = RegAddrBusW,
    parameter int DW    = RegBusW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_waddr,
    input  logic [DW-1:0] ld_wdata,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_waddr,
    input  logic [DW-1:0] alu_wdata,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    input  logic [AW-1:0] chk_addr,
    output logic          chk_pending
`ifdef WB_FWD_EN
    ,
    output logic          chk_fwd_valid,
    output logic [DW-1:0] chk_fwd_data
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);
    localparam logic [CW-1:0] OneC   = CW'(1);
    localparam logic [CW-1:0] TwoC   = CW'(2);

    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic [AW-1:0] q_addr [DEPTH];
    logic [DW-1:0] q_data [DEPTH];
    logic          ld_fire, alu_fire;
    logic          push_ld, push_alu;

    // Free space ignores the same-cycle pop so ready never depends on the drain path.
    assign free      = DepthC - count;
    assign ld_ready  = (free >= OneC);
    assign alu_ready = (free >= TwoC) | ((free == OneC) & ~ld_valid);

    assign ld_fire  = ld_valid & ld_ready;
    assign alu_fire = alu_valid & alu_ready;
    // Writes to r0 finish the handshake but never occupy an entry.
    assign push_ld  = ld_fire & (ld_waddr != '0);
    assign push_alu = alu_fire & (alu_waddr != '0);

    wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .push_a_i      (push_ld),
        .push_a_addr_i (ld_waddr),
        .push_a_data_i (ld_wdata),
        .push_b_i      (push_alu),
        .push_b_addr_i (alu_waddr),
        .push_b_data_i (alu_wdata),
        .pop_i         (we),
        .rd_ptr_o      (rd_ptr),
        .count_o       (count),
        .addr_o        (q_addr),
        .data_o        (q_data)
    );

    assign we    = (count != '0) ? WriteEnable : WriteDisable;
    assign waddr = we ? q_addr[rd_ptr] : '0;
    assign wdata = we ? q_data[rd_ptr] : DW'(ZeroWord);

`ifdef WB_FWD_EN
    logic [DW-1:0] fwd_data;
`endif

    // Walk from head to tail; a later hit is younger, so it overrides the forwarded data.
    always_comb begin : hazard_scan
        logic [PW-1:0] idx;
        chk_pending = 1'b0;
`ifdef WB_FWD_EN
        fwd_data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if ((CW'(k) < count) && (q_addr[idx] == chk_addr) && (chk_addr != '0)) begin
                chk_pending = 1'b1;
`ifdef WB_FWD_EN
                fwd_data = q_data[idx];
`endif
            end
        end
    end

`ifdef WB_FWD_EN
    assign chk_fwd_valid = chk_pending;
    assign chk_fwd_data  = fwd_data;
`endif

endmodule : reg_wb_queue

// File: tb/tb_reg_wb_queue.sv
// Scoreboard bench for reg_wb_queue: a queue model predicts readys, drained writes and hazard flags.
module tb_reg_wb_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid, alu_valid;
    logic          ld_ready, alu_ready;
    logic [AW-1:0] ld_waddr, alu_waddr, chk_addr;
    logic [DW-1:0] ld_wdata, alu_wdata;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          chk_pending;
`ifdef WB_FWD_EN
    logic          chk_fwd_valid;
    logic [DW-1:0] chk_fwd_data;
`endif

    int   checks   = 0;
    int   failures = 0;
    ent_t sb[$];

    always #5 clk = ~clk;

    reg_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_waddr    (ld_waddr),
        .ld_wdata    (ld_wdata),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_waddr   (alu_waddr),
        .alu_wdata   (alu_wdata),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .chk_addr    (chk_addr),
        .chk_pending (chk_pending)
`ifdef WB_FWD_EN
        ,
        .chk_fwd_valid (chk_fwd_valid),
        .chk_fwd_data  (chk_fwd_data)
`endif
    );

    task automatic drive(input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ldd,
                         input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad);
        ld_valid  = lv;  ld_waddr  = la; ld_wdata  = ldd;
        alu_valid = av;  alu_waddr = aa; alu_wdata = ad;
    endtask

    // One clock: compare outputs against the model, then advance the model at the edge.
    task automatic tick();
        int            free;
        logic          e_ld, e_alu, e_we, e_pend;
        logic [DW-1:0] e_fwd;
        #1;
        free  = DEPTH - sb.size();
        e_ld  = (free >= 1);
        e_alu = (free >= 2) || (free == 1 && !ld_valid);
        e_we  = (sb.size() != 0);
        checks++;
        if (ld_ready !== e_ld) begin
            failures++; $display("FAIL ld_ready got=%b exp=%b t=%0t", ld_ready, e_ld, $time);
        end
        checks++;
        if (alu_ready !== e_alu) begin
            failures++; $display("FAIL alu_ready got=%b exp=%b t=%0t", alu_ready, e_alu, $time);
        end
        checks++;
        if (we !== e_we) begin
            failures++; $display("FAIL we got=%b exp=%b t=%0t", we, e_we, $time);
        end else if (e_we) begin
            checks++;
            if (waddr !== sb[0].a || wdata !== sb[0].d) begin
                failures++;
                $display("FAIL write got=r%0d/%h exp=r%0d/%h t=%0t", waddr, wdata, sb[0].a, sb[0].d, $time);
            end
        end else begin
            checks++;
            if (waddr !== '0 || wdata !== '0) begin
                failures++; $display("FAIL idle_bus got=r%0d/%h exp=0/0 t=%0t", waddr, wdata, $time);
            end
        end
        e_pend = 1'b0;
        e_fwd  = '0;
        foreach (sb[i]) if (chk_addr != '0 && sb[i].a == chk_addr) begin
            e_pend = 1'b1; e_fwd = sb[i].d;
        end
        checks++;
        if (chk_pending !== e_pend) begin
            failures++; $display("FAIL chk_pending r%0d got=%b exp=%b t=%0t", chk_addr, chk_pending, e_pend, $time);
        end
`ifdef WB_FWD_EN
        checks++;
        if (chk_fwd_valid !== e_pend || (e_pend && chk_fwd_data !== e_fwd)) begin
            failures++;
            $display("FAIL chk_fwd got=%b/%h exp=%b/%h t=%0t", chk_fwd_valid, chk_fwd_data, e_pend, e_fwd, $time);
        end
`endif
        @(posedge clk);
        if (e_we) void'(sb.pop_front());
        if (ld_valid && e_ld && ld_waddr != '0) sb.push_back({ld_waddr, ld_wdata});
        if (alu_valid && e_alu && alu_waddr != '0) sb.push_back({alu_waddr, alu_wdata});
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, '0, '0, 0, '0, '0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(0, '0, '0, 0, '0, '0);
        chk_addr = '0;
        #12;
        checks++;
        if (we !== 1'b0 || waddr !== '0 || wdata !== '0) begin
            failures++; $display("FAIL reset_out got=%b/r%0d/%h exp=0/0/0", we, waddr, wdata);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        idle(1);
        // Build three queued entries, then reset in the middle of draining them.
        drive(1, 5'd1, 32'h11, 1, 5'd2, 32'h22); tick();
        drive(1, 5'd3, 32'h33, 1, 5'd4, 32'h44); tick();
        drive(0, '0, '0, 0, '0, '0);
        chk_addr = 5'd3;
        #1;
        checks++;
        if (we !== 1'b1 || sb.size() != 3) begin
            failures++; $display("FAIL pre_reset_fill got we=%b model=%0d exp=1/3", we, sb.size());
        end
        rst = 1'b0;
        #1;
        checks++;
        if (we !== 1'b0 || waddr !== '0 || wdata !== '0 || chk_pending !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got=%b/r%0d/%h/%b exp=0/0/0/0", we, waddr, wdata, chk_pending);
        end
        sb.delete();
        #2;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        chk_addr = 5'd5;
        drive(1, 5'd5, 32'h1234, 0, '0, '0); tick();
        drive(0, '0, '0, 0, '0, '0);
        #1;
        checks++;
        if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'h1234) begin
            failures++; $display("FAIL latency_n1 got=%b/r%0d/%h exp=1/r5/00001234", we, waddr, wdata);
        end
        tick();
        #1;
        checks++;
        if (we !== 1'b0) begin
            failures++; $display("FAIL latency_n2 got we=%b exp=0", we);
        end
        tick();
    endtask

    task automatic test_dual_push();
        chk_addr = 5'd3;
        drive(1, 5'd2, 32'hA, 1, 5'd3, 32'hB); tick();
        idle(3);
    endtask

    task automatic test_fill();
        chk_addr = 5'd10;
        drive(1, 5'd8,  32'h80, 1, 5'd9,  32'h90); tick();
        drive(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0); tick();
        drive(1, 5'd12, 32'hC0, 1, 5'd13, 32'hD0);
        #1;
        checks++;
        if (ld_ready !== 1'b1 || alu_ready !== 1'b0) begin
            failures++; $display("FAIL free1_both got ld=%b alu=%b exp ld=1 alu=0", ld_ready, alu_ready);
        end
        tick();
        drive(0, '0, '0, 1, 5'd13, 32'hD0);
        #1;
        checks++;
        if (alu_ready !== 1'b1) begin
            failures++; $display("FAIL free1_alu_only got alu=%b exp=1", alu_ready);
        end
        tick();
        idle(5);
    endtask

    task automatic test_r0();
        chk_addr = '0;
        drive(0, '0, '0, 1, 5'd0, 32'hDEAD); tick();
        drive(1, 5'd0, 32'hBEEF, 0, '0, '0); tick();
        drive(0, '0, '0, 0, '0, '0);
        #1;
        checks++;
        if (we !== 1'b0 || chk_pending !== 1'b0) begin
            failures++; $display("FAIL r0_drop got we=%b pend=%b exp=0/0", we, chk_pending);
        end
        tick();
    endtask

    task automatic test_same_addr();
        chk_addr = 5'd7;
        drive(1, 5'd7, 32'h1, 0, '0, '0); tick();
        drive(0, '0, '0, 1, 5'd7, 32'h2);
        #1;
        checks++;
        if (chk_pending !== 1'b1) begin
            failures++; $display("FAIL same_addr_pend got=%b exp=1", chk_pending);
        end
        tick();
        idle(4);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom());
            chk_addr = 5'($urandom_range(0, 7));
            tick();
        end
        idle(DEPTH + 2);
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL drain_empty got model=%0d exp=0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_dual_push();
        test_fill();
        test_r0();
        test_same_addr();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_wb_queue
